text2num_stream: RTL

//  Streaming ASCII-to-binary number parser, the successor to the single-char nibble decoder.

---
 rtl/text2num_pkg.sv | 28 ++
 rtl/ascii_digit_decode.sv | 28 ++
 rtl/text2num_stream.sv | 114 +++++++++++
 3 files changed

// File: rtl/text2num_pkg.sv
// Shared definitions for the streaming ASCII-to-number parser: state encoding,
// ASCII code points and a small range helper.
package text2num_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_ACC  = S_ACC,
    ST_OUT  = S_OUT
  } state_e;

  localparam logic [7:0] CH_0 = 8'h30;
  localparam logic [7:0] CH_9 = 8'h39;
  localparam logic [7:0] CH_a = 8'h61;
  localparam logic [7:0] CH_f = 8'h66;
  localparam logic [7:0] CH_A = 8'h41;
  localparam logic [7:0] CH_F = 8'h46;

  function automatic logic in_range(input logic [7:0] c,
                                    input logic [7:0] lo,
                                    input logic [7:0] hi);
    return (c >= lo) && (c <= hi);
  endfunction

endpackage

// File: rtl/ascii_digit_decode.sv
// Combinational ASCII digit classifier: decimal always, hex letters when hex_en.
// Non-digits report val=4'hF so downstream never sees an undefined nibble.
module ascii_digit_decode
  import text2num_pkg::*;
(
  input  logic [7:0] ch,
  input  logic       hex_en,
  output logic       is_digit,
  output logic [3:0] val
);

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    is_digit = 1'b0;
    val      = 4'hF;
    if (in_range(ch, CH_0, CH_9)) begin
      is_digit = 1'b1;
      val      = 4'(ch - CH_0);
    end else if (hex_en && in_range(ch, CH_a, CH_f)) begin
      is_digit = 1'b1;
      val      = 4'(ch - CH_a + 8'd10);
    end else if (hex_en && in_range(ch, CH_A, CH_F)) begin
      is_digit = 1'b1;
      val      = 4'(ch - CH_A + 8'd10);
    end
  end

endmodule

// File: rtl/text2num_stream.sv
// Streaming ASCII-to-binary number parser: accumulates a run of decimal or hex
// digits and emits the value (saturated, with an error flag on overflow) at the terminator.
module text2num_stream
  import text2num_pkg::*;
#(
  parameter int unsigned VAL_W  = 16,
  parameter bit          HEX_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic [7:0]       i_data,
  output logic             i_ready,
  input  logic             mode_hex,
  output logic             o_valid,
  output logic [VAL_W-1:0] o_data,
  output logic             o_err,
  input  logic             o_ready
);

  state_e           r_state;
  logic [VAL_W-1:0] r_acc;
  logic             r_ovf;
  logic             r_hex;
  logic             r_o_valid;
  logic [VAL_W-1:0] r_o_data;
  logic             r_o_err;

  logic             w_hex_sel;
  logic             w_is_digit;
  logic [3:0]       w_dval;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic [VAL_W+3:0] w_acc_ext;
  logic [VAL_W+3:0] w_acc_scaled;
  logic [VAL_W+3:0] w_acc_next;

  // The first digit of a number is classified with the live mode_hex; later
  // digits use the radix latched with it.
  assign w_hex_sel = (r_state == ST_IDLE) ? (mode_hex & HEX_EN) : r_hex;

  ascii_digit_decode u_decode (
    .ch       (i_data),
    .hex_en   (w_hex_sel),
    .is_digit (w_is_digit),
    .val      (w_dval)
  );

  assign i_ready    = (r_state != ST_OUT);
  assign w_in_xfer  = i_valid & i_ready;
  assign w_out_xfer = r_o_valid & o_ready;

  // Four guard bits catch any carry out of acc*base+d; x10 is built as x8+x2.
  assign w_acc_ext    = {4'b0000, r_acc};
  assign w_acc_scaled = r_hex ? (w_acc_ext << 4)
                              : ((w_acc_ext << 3) + (w_acc_ext << 1));
  assign w_acc_next   = w_acc_scaled + {{VAL_W{1'b0}}, w_dval};

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_acc     <= '0;
      r_ovf     <= 1'b0;
      r_hex     <= 1'b0;
      r_o_valid <= 1'b0;
      r_o_data  <= '0;
      r_o_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_in_xfer && w_is_digit) begin
            r_hex   <= w_hex_sel;
            r_acc   <= VAL_W'(w_dval);
            r_ovf   <= 1'b0;
            r_state <= ST_ACC;
          end
        end

        ST_ACC: begin
          if (w_in_xfer) begin
            if (w_is_digit) begin
              r_acc <= w_acc_next[VAL_W-1:0];
              if (|w_acc_next[VAL_W+3:VAL_W]) begin
                r_ovf <= 1'b1;
              end
            end else begin
              r_o_data  <= r_ovf ? {VAL_W{1'b1}} : r_acc;
              r_o_err   <= r_ovf;
              r_o_valid <= 1'b1;
              r_state   <= ST_OUT;
            end
          end
        end

        ST_OUT: begin
          if (w_out_xfer) begin
            r_o_valid <= 1'b0;
            r_acc     <= '0;
            r_state   <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_valid = r_o_valid;
  assign o_data  = r_o_data;
  assign o_err   = r_o_err;

endmodule
